// File: rtl/gate_sweep_ctrl.sv
// Gate-network sweep sequencer: walks a 6-bit vector range, settles, samples Y, counts ones.
// Optional MISR signature output enabled by defining GATE_SWEEP_SIG_EN.
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned NIN    = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [NIN-1:0] first,
    input  logic [NIN-1:0] last,
    output logic [NIN-1:0] gate_in,
    input  logic           gate_y,
    output logic           busy,
    output logic           done,
    output logic [NIN:0]   ones_cnt,
    output logic [NIN:0]   vec_cnt
`ifdef GATE_SWEEP_SIG_EN
    ,
    output logic [15:0]    sig
`endif
);

    typedef enum logic [1:0] {StIdle, StWait, StSample, StDone} state_t;

    localparam logic [3:0] SettleInit = 4'(SETTLE);

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [NIN-1:0] gate_q, gate_d;
    logic [NIN-1:0] last_q, last_d;
    logic [NIN:0]   ones_q, ones_d;
    logic [NIN:0]   vec_q, vec_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
`ifdef GATE_SWEEP_SIG_EN
    logic [15:0]    sig_q, sig_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gate_d  = gate_q;
        last_d  = last_q;
        ones_d  = ones_q;
        vec_d   = vec_q;
`ifdef GATE_SWEEP_SIG_EN
        sig_d   = sig_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    gate_d  = first;
                    last_d  = last;
                    ones_d  = '0;
                    vec_d   = '0;
                    cnt_d   = SettleInit;
`ifdef GATE_SWEEP_SIG_EN
                    sig_d   = '0;
`endif
                    state_d = (SETTLE != 0) ? StWait : StSample;
                end
            end
            StWait: begin
                if (abort) begin
                    state_d = StIdle;
                    gate_d  = '0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StSample: begin
                if (abort) begin
                    // An aborted sample is discarded entirely.
                    state_d = StIdle;
                    gate_d  = '0;
                end else begin
                    ones_d = ones_q + {{NIN{1'b0}}, gate_y};
                    vec_d  = vec_q + 1'b1;
`ifdef GATE_SWEEP_SIG_EN
                    sig_d  = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3]}
                             ^ {15'b0, gate_y};
`endif
                    if (gate_q == last_q) begin
                        state_d = StDone;
                    end else begin
                        gate_d  = gate_q + 1'b1;
                        cnt_d   = SettleInit;
                        state_d = (SETTLE != 0) ? StWait : StSample;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d == StWait) || (state_d == StSample);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            gate_q  <= '0;
            last_q  <= '0;
            ones_q  <= '0;
            vec_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef GATE_SWEEP_SIG_EN
            sig_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            last_q  <= last_d;
            ones_q  <= ones_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef GATE_SWEEP_SIG_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign gate_in  = gate_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ones_cnt = ones_q;
    assign vec_cnt  = vec_q;
`ifdef GATE_SWEEP_SIG_EN
    assign sig      = sig_q;
`endif

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized self-checking bench for gate_sweep_ctrl against a range/count reference model.
// Signature checks are compiled in when GATE_SWEEP_SIG_EN is defined.
module tb_gate_sweep_ctrl;

    localparam int S = 2;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [5:0]  first;
    logic [5:0]  last;
    logic [5:0]  gate_in;
    logic        gate_y;
    logic        busy;
    logic        done;
    logic [6:0]  ones_cnt;
    logic [6:0]  vec_cnt;
`ifdef GATE_SWEEP_SIG_EN
    logic [15:0] sig;
    logic [15:0] sig_prev;
`endif

    // Gate network: truth table indexed by the applied vector, optional forced-one vector.
    logic [63:0] truth;
    logic        force_en;
    logic [5:0]  force_v;

    int vectors;
    int errors;

    gate_sweep_ctrl #(.SETTLE(S), .NIN(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .first    (first),
        .last     (last),
        .gate_in  (gate_in),
        .gate_y   (gate_y),
        .busy     (busy),
        .done     (done),
        .ones_cnt (ones_cnt),
        .vec_cnt  (vec_cnt)
`ifdef GATE_SWEEP_SIG_EN
        ,
        .sig      (sig)
`endif
    );

    assign gate_y = (force_en && gate_in == force_v) ? 1'b1 : truth[gate_in];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic y_ref(input logic [5:0] v);
        return (force_en && v == force_v) ? 1'b1 : truth[v];
    endfunction

    // Expected totals for a sweep f..l, optionally cut short by an abort in cycle abort_at.
    function automatic void model(input logic [5:0] f, input logic [5:0] l, input int abort_at,
                                  output int n, output int nv, output int no,
                                  output logic [15:0] s);
        logic [5:0] d;
        logic [5:0] v;
        logic       y;
        d  = l - f;
        n  = int'(d) + 1;
        nv = 0;
        no = 0;
        s  = '0;
        for (int i = 0; i < n; i++) begin
            if (abort_at > 0 && (i + 1) * (S + 1) >= abort_at) break;
            v  = f + 6'(i);
            y  = y_ref(v);
            nv++;
            no += int'(y);
            s  = {s[14:0], s[15] ^ s[14] ^ s[12] ^ s[3]} ^ {15'b0, y};
        end
    endfunction

    task automatic sweep(input logic [5:0] f, input logic [5:0] l, input int abort_at,
                         input int start_at);
        int          n, nv, no, c, dc;
        logic [15:0] es;
        logic [5:0]  ev;
        model(f, l, abort_at, n, nv, no, es);
        dc = n * (S + 1) + 1;
        @(negedge clk);
        first = f;
        last  = l;
        start = 1'b1;
        abort = 1'b0;
        @(negedge clk);
        start = 1'b0;
        first = 6'($urandom);
        last  = 6'($urandom);
        c = 1;
        forever begin
            if (abort_at > 0 && c == abort_at + 1) begin
                check_val("abort_busy", busy, 0);
                check_val("abort_gate_in", gate_in, 0);
                check_val("abort_vec_cnt", vec_cnt, nv);
                check_val("abort_ones_cnt", ones_cnt, no);
                check_val("abort_done", done, 0);
`ifdef GATE_SWEEP_SIG_EN
                check_val("abort_sig", sig, es);
`endif
                repeat (3) begin
                    @(negedge clk);
                    check_val("abort_no_done", done, 0);
                end
                break;
            end
            if (done) begin
                check_val("done_cycle", c, dc);
                check_val("vec_cnt", vec_cnt, nv);
                check_val("ones_cnt", ones_cnt, no);
                check_val("final_gate_in", gate_in, l);
                check_val("done_busy", busy, 0);
`ifdef GATE_SWEEP_SIG_EN
                check_val("sig", sig, es);
`endif
                @(negedge clk);
                check_val("done_pulse_width", done, 0);
                check_val("vec_cnt_hold", vec_cnt, nv);
                check_val("gate_in_hold", gate_in, l);
                break;
            end
            if (c > dc + 4) begin
                check_val("done_timeout", c, dc);
                break;
            end
            check_val("busy", busy, 1);
            if (c % (S + 1) == 0) begin
                ev = f + 6'(c / (S + 1) - 1);
                check_val("vector", gate_in, ev);
            end
            start = (c == start_at);
            abort = (c == abort_at);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    initial begin
        logic [5:0] rf, rl, d;
        int         n, ab, st;
        vectors  = 0;
        errors   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        first    = '0;
        last     = '0;
        truth    = '0;
        force_en = 1'b0;
        force_v  = '0;
        #1;
        check_val("rst_gate_in", gate_in, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_ones_cnt", ones_cnt, 0);
        check_val("rst_vec_cnt", vec_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // AND6 full range, OR6 wrapping range, single vector.
        truth = 64'h1 << 63;
        sweep(6'd0, 6'd63, 0, 0);
        truth = ~64'h1;
        sweep(6'd60, 6'd3, 0, 0);
        truth = 64'h1 << 63;
        sweep(6'h2A, 6'h2A, 0, 0);
        // first = last + 1 covers all 64 vectors.
        sweep(6'd20, 6'd19, 0, 0);

        // Abort in cycle 10 with an ignored start in cycle 5.
        sweep(6'd0, 6'd63, 10, 5);

        // Reset mid-WAIT.
        @(negedge clk);
        first = 6'd10;
        last  = 6'd40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_gate_in", gate_in, 0);
        check_val("mid_rst_busy", busy, 0);
        check_val("mid_rst_done", done, 0);
        check_val("mid_rst_ones_cnt", ones_cnt, 0);
        check_val("mid_rst_vec_cnt", vec_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sweep(6'd0, 6'd63, 0, 0);

        // Random gate tables, ranges, aborts and ignored starts.
        for (int k = 0; k < 12; k++) begin
            truth = {$urandom, $urandom};
            rf    = 6'($urandom);
            rl    = 6'($urandom);
            d     = rl - rf;
            n     = int'(d) + 1;
            ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n * (S + 1))) : 0;
            st    = int'($urandom_range(1, n * (S + 1)));
            sweep(rf, rl, ab, st);
        end

`ifdef GATE_SWEEP_SIG_EN
        truth = 64'h1 << 63;
        sweep(6'd0, 6'd63, 0, 0);
        sig_prev = sig;
        sweep(6'd0, 6'd63, 0, 0);
        check_val("sig_repeat", sig, sig_prev);
        force_en = 1'b1;
        force_v  = 6'd5;
        sweep(6'd0, 6'd63, 0, 0);
        check_val("sig_force_differs", 32'(sig != sig_prev), 1);
        force_en = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
